// File: rtl/expr_gen_fifo_if.sv
// Control, handshake and status bundle for the expression generator FIFO.
interface expr_gen_fifo_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LvlW = $clog2(DEPTH) + 1;

  logic            en;
  logic            seed_load;
  logic [15:0]     seed;
  logic            out_valid;
  logic            out_ready;
  logic [11:0]     exp;
  logic [1:0]      line;
  logic [LvlW-1:0] level;

  // Producer/consumer side driving the generator.
  modport master (
    output en, seed_load, seed, out_ready,
    input  out_valid, exp, line, level
  );

  // Generator side.
  modport slave (
    input  en, seed_load, seed, out_ready,
    output out_valid, exp, line, level
  );
endinterface

// File: rtl/expr_gen_fifo.sv
// LFSR-driven arithmetic expression generator feeding a small output FIFO.
// Each attempt draws one candidate {num1, op, num2} plus a line index; inexact
// divisions are redrawn up to MAX_RETRY times, then forced to divide by 1.
module expr_gen_fifo #(
  parameter int unsigned NUM_MAX   = 9,
  parameter int unsigned LINES     = 3,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DIV_EN    = 1,
  parameter int unsigned MAX_RETRY = 7
) (
  input logic             clk,
  input logic             rst,
  expr_gen_fifo_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  localparam logic [15:0] SeedDefault = 16'hACE1;
  localparam logic [3:0]  OpAdd = 4'hA;
  localparam logic [3:0]  OpSub = 4'hB;
  localparam logic [3:0]  OpMul = 4'hC;
  localparam logic [3:0]  OpDiv = 4'hD;

  typedef enum logic [1:0] {StIdle, StGen, StRetry} state_e;

  logic [15:0]     lfsr_q;
  logic [15:0]     lfsr_next;
  logic [3:0]      retry_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [LvlW-1:0] level_q;
  logic [13:0]     mem_q [DEPTH];

  logic [3:0]      cand_a;
  logic [3:0]      cand_b;
  logic [3:0]      opr;
  logic [3:0]      op;
  logic [3:0]      num1;
  logic [3:0]      num2;
  logic [3:0]      num2_fin;
  logic [1:0]      line_idx;
  logic            div_inexact;
  logic            attempt;
  logic            push;
  logic            pop;
  logic [13:0]     head;
  state_e          st;

  // Candidate decode from the current LFSR value and the per-cycle action.
  always_comb begin
    lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    cand_a    = 4'(lfsr_q[5:0] % 6'(NUM_MAX)) + 4'd1;
    cand_b    = 4'(lfsr_q[11:6] % 6'(NUM_MAX)) + 4'd1;
    opr       = lfsr_q[15:12];
    op        = OpAdd + {2'b00, opr[1:0]};
    if (DIV_EN == 0 && op == OpDiv) begin
      op = OpMul;
    end
    line_idx  = 2'(opr % 4'(LINES));

    // Subtraction never goes negative: larger operand first.
    if (op == OpSub && cand_a < cand_b) begin
      num1 = cand_b;
      num2 = cand_a;
    end else begin
      num1 = cand_a;
      num2 = cand_b;
    end

    // num2 is at least 1, so the modulo is always defined.
    div_inexact = (op == OpDiv) && ((num1 % num2) != 4'd0);
    num2_fin    = div_inexact ? 4'd1 : num2;

    // Occupancy is taken at cycle start; a concurrent pop does not open a slot.
    attempt = bus.en && !bus.seed_load && !rst && (level_q < LvlW'(DEPTH));

    if (!attempt) begin
      st = StIdle;
    end else if (div_inexact && (retry_q < 4'(MAX_RETRY))) begin
      st = StRetry;
    end else begin
      st = StGen;
    end

    push = (st == StGen);
    pop  = (level_q != '0) && bus.out_ready && !rst;
  end

  // Generator state: LFSR and division retry counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q  <= SeedDefault;
      retry_q <= 4'd0;
    end else if (bus.seed_load) begin
      lfsr_q  <= (bus.seed == 16'd0) ? SeedDefault : bus.seed;
      retry_q <= 4'd0;
    end else begin
      unique case (st)
        StGen: begin
          lfsr_q  <= lfsr_next;
          retry_q <= 4'd0;
        end
        StRetry: begin
          lfsr_q  <= lfsr_next;
          retry_q <= retry_q + 4'd1;
        end
        StIdle: begin
          lfsr_q  <= lfsr_q;
          retry_q <= retry_q;
        end
        default: begin
          lfsr_q  <= lfsr_q;
          retry_q <= retry_q;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_q + LvlW'(push) - LvlW'(pop);
    end
  end

  // Entry storage is deliberately not reset; empty-state masking hides stale data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {line_idx, num1, op, num2_fin};
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.out_valid = (level_q != '0);
  assign bus.exp       = (level_q != '0) ? head[11:0] : 12'd0;
  assign bus.line      = (level_q != '0) ? head[13:12] : 2'd0;
  assign bus.level     = level_q;

endmodule

// File: tb/tb_expr_gen_fifo.sv
// Directed checks with hand-computed entries, then a random soak against a
// reference model of the generator and FIFO.
module tb_expr_gen_fifo;

  logic clk;
  logic rst0;
  logic rst1;

  int n_checks;
  int n_errors;

  expr_gen_fifo_if #(.DEPTH(4)) bus0 ();
  expr_gen_fifo_if #(.DEPTH(4)) bus1 ();

  expr_gen_fifo #(
    .NUM_MAX   (9),
    .LINES     (3),
    .DEPTH     (4),
    .DIV_EN    (1),
    .MAX_RETRY (7)
  ) u_dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0)
  );

  expr_gen_fifo #(
    .NUM_MAX   (9),
    .LINES     (3),
    .DEPTH     (4),
    .DIV_EN    (1),
    .MAX_RETRY (0)
  ) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state for u_dut0.
  logic [15:0] m_lfsr;
  int          m_retry;
  logic [13:0] m_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_step(input bit e, input bit sl, input logic [15:0] sd, input bit rdy);
    bit   do_attempt;
    bit   do_pop;
    int   a, b, o, opc, n1, n2;
    bit   inexact;
    do_attempt = e && !sl && (m_q.size() < 4);
    do_pop     = (m_q.size() > 0) && rdy;
    if (do_pop) void'(m_q.pop_front());
    if (sl) begin
      m_lfsr  = (sd == 16'd0) ? 16'hACE1 : sd;
      m_retry = 0;
    end else if (do_attempt) begin
      a   = int'(m_lfsr[5:0]) % 9 + 1;
      b   = int'(m_lfsr[11:6]) % 9 + 1;
      o   = int'(m_lfsr[15:12]);
      opc = 10 + o % 4;
      if (opc == 11 && a < b) begin
        n1 = b; n2 = a;
      end else begin
        n1 = a; n2 = b;
      end
      inexact = (opc == 13) && ((n1 % n2) != 0);
      if (inexact && m_retry < 7) begin
        m_retry++;
      end else begin
        if (inexact) n2 = 1;
        m_q.push_back({2'(o % 3), 4'(n1), 4'(opc), 4'(n2)});
        m_retry = 0;
      end
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  endtask

  task automatic cyc(input bit e, input bit sl, input logic [15:0] sd, input bit rdy);
    bus0.en        = e;
    bus0.seed_load = sl;
    bus0.seed      = sd;
    bus0.out_ready = rdy;
    m_step(e, sl, sd, rdy);
    step();
  endtask

  // Reset with every other control asserted to show reset wins.
  task automatic do_reset();
    rst0           = 1'b1;
    bus0.en        = 1'b1;
    bus0.seed_load = 1'b1;
    bus0.seed      = 16'h1234;
    bus0.out_ready = 1'b1;
    step();
    rst0    = 1'b0;
    m_lfsr  = 16'hACE1;
    m_retry = 0;
    m_q.delete();
  endtask

  initial begin
    logic [11:0] e;
    n_checks = 0;
    n_errors = 0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    bus0.en = 1'b0; bus0.seed_load = 1'b0; bus0.seed = 16'd0; bus0.out_ready = 1'b0;
    bus1.en = 1'b0; bus1.seed_load = 1'b0; bus1.seed = 16'd0; bus1.out_ready = 1'b0;

    // Reset state.
    do_reset();
    check("rst_valid", 32'(bus0.out_valid), 32'd0);
    check("rst_exp", 32'(bus0.exp), 32'd0);
    check("rst_line", 32'(bus0.line), 32'd0);
    check("rst_level", 32'(bus0.level), 32'd0);
    check("rst_lfsr", 32'(u_dut0.lfsr_q), 32'hACE1);

    // First two entries, including the subtraction swap.
    cyc(1, 0, 16'd0, 0);
    check("e1_valid", 32'(bus0.out_valid), 32'd1);
    check("e1_exp", 32'(bus0.exp), 32'h7C7);
    check("e1_line", 32'(bus0.line), 32'd1);
    cyc(1, 0, 16'd0, 0);
    check("e2_level", 32'(bus0.level), 32'd2);
    cyc(0, 0, 16'd0, 1);
    check("e2_exp", 32'(bus0.exp), 32'h8B4);
    check("e2_line", 32'(bus0.line), 32'd2);
    check("e2_level_after_pop", 32'(bus0.level), 32'd1);

    // Backpressure: fill, saturate, LFSR freeze.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 0, 16'd0, 0);
    check("bp_full", 32'(bus0.level), 32'd4);
    cyc(1, 0, 16'd0, 0);
    check("bp_sat", 32'(bus0.level), 32'd4);
    check("bp_lfsr_frozen", 32'(u_dut0.lfsr_q), 32'h2ACE);
    // Pop plus attempt on a full FIFO: no push.
    cyc(1, 0, 16'd0, 1);
    check("bp_pop_level", 32'(bus0.level), 32'd3);
    check("bp_pop_lfsr", 32'(u_dut0.lfsr_q), 32'h2ACE);
    check("bp_pop_head", 32'(bus0.exp), 32'h8B4);
    cyc(1, 0, 16'd0, 0);
    check("bp_refill", 32'(bus0.level), 32'd4);
    check("bp_refill_lfsr", 32'(u_dut0.lfsr_q), 32'h1567);

    // Seed zero loads the default seed and keeps FIFO contents.
    cyc(1, 1, 16'd0, 0);
    check("sz_level_kept", 32'(bus0.level), 32'd4);
    check("sz_lfsr", 32'(u_dut0.lfsr_q), 32'hACE1);
    check("sz_head_kept", 32'(bus0.exp), 32'h8B4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 16'd0, 1);
    check("drain_valid", 32'(bus0.out_valid), 32'd0);
    check("drain_exp", 32'(bus0.exp), 32'd0);
    check("drain_line", 32'(bus0.line), 32'd0);
    cyc(1, 0, 16'd0, 0);
    check("sz_exp", 32'(bus0.exp), 32'h7C7);
    check("sz_line", 32'(bus0.line), 32'd1);

    // Division redraw with MAX_RETRY=7.
    cyc(0, 0, 16'd0, 1);
    cyc(0, 1, 16'h3046, 0);
    cyc(1, 0, 16'd0, 0);
    check("rt_level", 32'(bus0.level), 32'd0);
    check("rt_valid", 32'(bus0.out_valid), 32'd0);
    check("rt_retry", 32'(u_dut0.retry_q), 32'd1);
    check("rt_lfsr", 32'(u_dut0.lfsr_q), 32'h9823);
    // Reset mid-retry.
    do_reset();
    check("rt_rst_retry", 32'(u_dut0.retry_q), 32'd0);
    check("rt_rst_lfsr", 32'(u_dut0.lfsr_q), 32'hACE1);

    // Reset on a full FIFO.
    for (int i = 0; i < 5; i++) cyc(1, 0, 16'd0, 0);
    check("rf_full", 32'(bus0.level), 32'd4);
    do_reset();
    check("rf_valid", 32'(bus0.out_valid), 32'd0);
    check("rf_level", 32'(bus0.level), 32'd0);
    check("rf_exp", 32'(bus0.exp), 32'd0);
    cyc(1, 0, 16'd0, 0);
    check("rf_first", 32'(bus0.exp), 32'h7C7);

    // Forced divide with MAX_RETRY=0 on the second instance.
    bus0.en = 1'b0; bus0.seed_load = 1'b0; bus0.out_ready = 1'b0;
    step();
    rst1 = 1'b0;
    bus1.seed_load = 1'b1;
    bus1.seed = 16'h3046;
    step();
    bus1.seed_load = 1'b0;
    bus1.en = 1'b1;
    step();
    bus1.en = 1'b0;
    check("fd_valid", 32'(bus1.out_valid), 32'd1);
    check("fd_exp", 32'(bus1.exp), 32'h7D1);
    check("fd_line", 32'(bus1.line), 32'd0);

    // Random soak against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
          ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom), $urandom_range(0, 1) == 1);
      check("sk_level", 32'(bus0.level), 32'(m_q.size()));
      check("sk_bound", 32'(bus0.level <= 3'd4), 32'd1);
      check("sk_valid", 32'(bus0.out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        check("sk_exp", 32'(bus0.exp), 32'(m_q[0][11:0]));
        check("sk_line", 32'(bus0.line), 32'(m_q[0][13:12]));
        e = bus0.exp;
        if (e[7:4] == 4'hB) check("sk_sub_nonneg", 32'(e[11:8] >= e[3:0]), 32'd1);
        if (e[7:4] == 4'hD) check("sk_div_exact",
                                  32'((e[3:0] != 4'd0) && ((e[11:8] % e[3:0]) == 4'd0)), 32'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
